// File: rtl/vcb_mod_cled.sv
// Modulus-m up/down counter with a runtime modulus, wrap/saturate mode,
// sticky terminal-event flag and a cascade enable for chaining digits.
module vcb_mod_cled #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SAT_DEF = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    input  logic             up,
    input  logic             l,
    input  logic [WIDTH-1:0] di,
    input  logic [WIDTH-1:0] m,
    input  logic             sat_wr,
    input  logic             sat_in,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ceo,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_sat;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_load_val;
    logic             w_term;
    logic             w_tc;

    assign w_load_val = (di <= m) ? di : m;
    assign w_tc       = up ? (r_q >= m) : (r_q == '0);

    // A count above a lowered modulus is pulled back to m when counting
    // down; that recovery is not a terminal event.
    always_comb begin
        w_q_nxt = r_q;
        w_term  = 1'b0;
        if (l) begin
            w_q_nxt = w_load_val;
        end else if (ce) begin
            if (up) begin
                if (r_q < m) begin
                    w_q_nxt = r_q + ONE;
                end else begin
                    w_term  = 1'b1;
                    w_q_nxt = r_sat ? m : '0;
                end
            end else begin
                if (r_q > m) begin
                    w_q_nxt = m;
                end else if (r_q == '0) begin
                    w_term  = 1'b1;
                    w_q_nxt = r_sat ? '0 : m;
                end else begin
                    w_q_nxt = r_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
            r_sat <= (SAT_DEF != 0);
        end else begin
            r_q <= w_q_nxt;
            if (w_term) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (sat_wr) begin
                r_sat <= sat_in;
            end
        end
    end

    assign q   = r_q;
    assign tc  = w_tc;
    assign ceo = ce & w_tc & ~l;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_vcb_mod_cled.sv
// Scoreboard bench for vcb_mod_cled: one DUT for single-counter behaviour
// plus a two-digit cascade (mod 10 low, mod 6 high).
module tb_vcb_mod_cled;

    logic       clk = 1'b0;
    logic       clr_n, ce, up, l, sat_wr, sat_in, ovf_clr;
    logic [3:0] di, m;
    logic [3:0] q;
    logic       tc, ceo, ovf;

    logic       cas_ce;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_ceo, lo_ovf, hi_tc, hi_ceo, hi_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] q;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       ce, up, l;
        logic [3:0] di, m;
        logic       sw, si, oc;
        logic       ptc, pceo;
        logic [3:0] eq;
        logic       eovf;
    } step_t;

    exp_t       sb[$];
    logic [7:0] csb[$];

    always #5 clk = ~clk;

    vcb_mod_cled #(.WIDTH(4), .SAT_DEF(0)) dut (
        .clk(clk), .clr_n(clr_n), .ce(ce), .up(up), .l(l), .di(di), .m(m),
        .sat_wr(sat_wr), .sat_in(sat_in), .ovf_clr(ovf_clr),
        .q(q), .tc(tc), .ceo(ceo), .ovf(ovf)
    );

    vcb_mod_cled #(.WIDTH(4), .SAT_DEF(0)) u_lo (
        .clk(clk), .clr_n(clr_n), .ce(cas_ce), .up(1'b1), .l(1'b0), .di(4'd0), .m(4'd9),
        .sat_wr(1'b0), .sat_in(1'b0), .ovf_clr(1'b0),
        .q(lo_q), .tc(lo_tc), .ceo(lo_ceo), .ovf(lo_ovf)
    );

    vcb_mod_cled #(.WIDTH(4), .SAT_DEF(0)) u_hi (
        .clk(clk), .clr_n(clr_n), .ce(lo_ceo), .up(1'b1), .l(1'b0), .di(4'd0), .m(4'd5),
        .sat_wr(1'b0), .sat_in(1'b0), .ovf_clr(1'b0),
        .q(hi_q), .tc(hi_tc), .ceo(hi_ceo), .ovf(hi_ovf)
    );

    function automatic step_t mk(int ce_i, int up_i, int l_i, int di_i, int m_i,
                                 int sw_i, int si_i, int oc_i, int ptc_i, int pceo_i,
                                 int eq_i, int eovf_i);
        step_t s;
        s.ce = 1'(ce_i);   s.up = 1'(up_i);   s.l = 1'(l_i);
        s.di = 4'(di_i);   s.m = 4'(m_i);
        s.sw = 1'(sw_i);   s.si = 1'(si_i);   s.oc = 1'(oc_i);
        s.ptc = 1'(ptc_i); s.pceo = 1'(pceo_i);
        s.eq = 4'(eq_i);   s.eovf = 1'(eovf_i);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        ce = 1'b0; up = 1'b1; l = 1'b0; di = 4'd0; m = 4'd9;
        sat_wr = 1'b0; sat_in = 1'b0; ovf_clr = 1'b0; cas_ce = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        ce = 1'b1; up = 1'b1; l = 1'b0; di = 4'd0; m = 4'd9;
        sat_wr = 1'b0; sat_in = 1'b0; ovf_clr = 1'b0; cas_ce = 1'b0;
        clr_n = 1'b1;
        #1;
        clr_n = 1'b0;
        #1;
        sb.push_back({4'd0, 1'b0});
        e = sb.pop_front();
        n_checks++;
        if ({q, ovf, tc} !== {e.q, e.ovf, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: q=%0d ovf=%b tc=%b, expected q=%0d ovf=%b tc=0", q, ovf, tc, e.q, e.ovf);
        end
        up = 1'b0;
        #1;
        n_checks++;
        if ({tc, ceo} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_down_tc_ceo: tc=%b ceo=%b, expected tc=1 ceo=1", tc, ceo);
        end
        l = 1'b1; di = 4'd6;
        sb.push_back({4'd0, 1'b0});
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({q, ovf} !== {e.q, e.ovf}) begin
            n_fail++;
            $display("FAIL reset_ignores_clk: q=%0d ovf=%b, expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
        end
    endtask

    task automatic test_up_wrap();
        exp_t e;
        do_reset();
        ce = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            sb.push_back({4'(i % 10), (i >= 10)});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({q, ovf, tc} !== {e.q, e.ovf, ((i % 10) == 9)}) begin
                n_fail++;
                $display("FAIL up_wrap[%0d]: q=%0d ovf=%b tc=%b, expected q=%0d ovf=%b tc=%b",
                         i, q, ovf, tc, e.q, e.ovf, ((i % 10) == 9));
            end
        end
    endtask

    task automatic test_down_sat();
        step_t st[$];
        exp_t  e;
        do_reset();
        //                ce up l di m sw si oc ptc pceo eq eovf
        st.push_back(mk(0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0));
        st.push_back(mk(0, 0, 1, 2, 9, 0, 0, 0, 1, 0, 2, 0));
        st.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 1, 1, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 1, 1, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 9, 0, 0, 1, 1, 1, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 9, 1, 0, 0, 1, 1, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 1, 1, 9, 1));
        st.push_back(mk(0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 9, 0));
        foreach (st[i]) begin
            ce = st[i].ce; up = st[i].up; l = st[i].l; di = st[i].di; m = st[i].m;
            sat_wr = st[i].sw; sat_in = st[i].si; ovf_clr = st[i].oc;
            #1;
            n_checks++;
            if ({tc, ceo} !== {st[i].ptc, st[i].pceo}) begin
                n_fail++;
                $display("FAIL down_sat[%0d] tc/ceo: got %b%b, expected %b%b", i, tc, ceo, st[i].ptc, st[i].pceo);
            end
            sb.push_back({st[i].eq, st[i].eovf});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({q, ovf} !== {e.q, e.ovf}) begin
                n_fail++;
                $display("FAIL down_sat[%0d] q/ovf: got q=%0d ovf=%b, expected q=%0d ovf=%b", i, q, ovf, e.q, e.ovf);
            end
        end
    endtask

    task automatic test_load_clamp();
        step_t st[$];
        exp_t  e;
        do_reset();
        //                ce up l di  m sw si oc ptc pceo eq eovf
        st.push_back(mk(0, 1, 1, 5,  5, 0, 0, 0, 0, 0, 5, 0));
        st.push_back(mk(1, 1, 1, 12, 5, 0, 0, 0, 1, 0, 5, 0));
        st.push_back(mk(0, 1, 1, 3,  5, 0, 0, 0, 1, 0, 3, 0));
        st.push_back(mk(1, 1, 0, 0,  5, 0, 0, 0, 0, 0, 4, 0));
        st.push_back(mk(1, 1, 0, 0,  5, 0, 0, 0, 0, 0, 5, 0));
        st.push_back(mk(1, 1, 0, 0,  5, 0, 0, 0, 1, 1, 0, 1));
        st.push_back(mk(1, 1, 1, 4,  5, 0, 0, 0, 0, 0, 4, 1));
        st.push_back(mk(0, 0, 1, 15, 5, 0, 0, 0, 0, 0, 5, 1));
        foreach (st[i]) begin
            ce = st[i].ce; up = st[i].up; l = st[i].l; di = st[i].di; m = st[i].m;
            sat_wr = st[i].sw; sat_in = st[i].si; ovf_clr = st[i].oc;
            #1;
            n_checks++;
            if ({tc, ceo} !== {st[i].ptc, st[i].pceo}) begin
                n_fail++;
                $display("FAIL load_clamp[%0d] tc/ceo: got %b%b, expected %b%b", i, tc, ceo, st[i].ptc, st[i].pceo);
            end
            sb.push_back({st[i].eq, st[i].eovf});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({q, ovf} !== {e.q, e.ovf}) begin
                n_fail++;
                $display("FAIL load_clamp[%0d] q/ovf: got q=%0d ovf=%b, expected q=%0d ovf=%b", i, q, ovf, e.q, e.ovf);
            end
        end
    endtask

    task automatic test_runtime_modulus();
        step_t st[$];
        exp_t  e;
        do_reset();
        //                ce up l di m sw si oc ptc pceo eq eovf
        st.push_back(mk(0, 1, 1, 8, 9, 0, 0, 0, 0, 0, 8, 0));
        st.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 1, 1, 0, 1));
        st.push_back(mk(0, 1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 8, 9, 0, 0, 0, 0, 0, 8, 0));
        st.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3, 0));
        st.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 2, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        st.push_back(mk(1, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 1));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        foreach (st[i]) begin
            ce = st[i].ce; up = st[i].up; l = st[i].l; di = st[i].di; m = st[i].m;
            sat_wr = st[i].sw; sat_in = st[i].si; ovf_clr = st[i].oc;
            #1;
            n_checks++;
            if ({tc, ceo} !== {st[i].ptc, st[i].pceo}) begin
                n_fail++;
                $display("FAIL runtime_mod[%0d] tc/ceo: got %b%b, expected %b%b", i, tc, ceo, st[i].ptc, st[i].pceo);
            end
            sb.push_back({st[i].eq, st[i].eovf});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({q, ovf} !== {e.q, e.ovf}) begin
                n_fail++;
                $display("FAIL runtime_mod[%0d] q/ovf: got q=%0d ovf=%b, expected q=%0d ovf=%b", i, q, ovf, e.q, e.ovf);
            end
        end
    endtask

    task automatic test_free_run_hold();
        step_t st[$];
        exp_t  e;
        do_reset();
        //                ce up l di  m  sw si oc ptc pceo eq eovf
        st.push_back(mk(0, 1, 1, 14, 15, 0, 0, 0, 0, 0, 14, 0));
        st.push_back(mk(1, 1, 0, 0,  15, 0, 0, 0, 0, 0, 15, 0));
        st.push_back(mk(1, 1, 0, 0,  15, 0, 0, 0, 1, 1, 0,  1));
        st.push_back(mk(1, 1, 0, 0,  15, 0, 0, 0, 0, 0, 1,  1));
        st.push_back(mk(1, 0, 0, 0,  15, 0, 0, 1, 0, 0, 0,  0));
        st.push_back(mk(1, 0, 0, 0,  15, 0, 0, 0, 1, 1, 15, 1));
        st.push_back(mk(1, 0, 0, 0,  15, 0, 0, 0, 0, 0, 14, 1));
        st.push_back(mk(0, 1, 0, 0,  15, 0, 0, 0, 0, 0, 14, 1));
        st.push_back(mk(0, 0, 0, 0,  15, 1, 1, 0, 0, 0, 14, 1));
        st.push_back(mk(1, 1, 1, 15, 15, 0, 0, 0, 0, 0, 15, 1));
        st.push_back(mk(1, 1, 0, 0,  15, 0, 0, 0, 1, 1, 15, 1));
        foreach (st[i]) begin
            ce = st[i].ce; up = st[i].up; l = st[i].l; di = st[i].di; m = st[i].m;
            sat_wr = st[i].sw; sat_in = st[i].si; ovf_clr = st[i].oc;
            #1;
            n_checks++;
            if ({tc, ceo} !== {st[i].ptc, st[i].pceo}) begin
                n_fail++;
                $display("FAIL free_run[%0d] tc/ceo: got %b%b, expected %b%b", i, tc, ceo, st[i].ptc, st[i].pceo);
            end
            sb.push_back({st[i].eq, st[i].eovf});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({q, ovf} !== {e.q, e.ovf}) begin
                n_fail++;
                $display("FAIL free_run[%0d] q/ovf: got q=%0d ovf=%b, expected q=%0d ovf=%b", i, q, ovf, e.q, e.ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        m = 4'd0; ce = 1'b1; up = 1'b1;
        tick();
        m = 4'd9;
        repeat (7) tick();
        sb.push_back({4'd7, 1'b1});
        e = sb.pop_front();
        n_checks++;
        if ({q, ovf} !== {e.q, e.ovf}) begin
            n_fail++;
            $display("FAIL async_pre: q=%0d ovf=%b, expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
        end
        #2;
        clr_n = 1'b0;
        l = 1'b1; di = 4'd5; sat_wr = 1'b1; sat_in = 1'b1; ovf_clr = 1'b1;
        #1;
        sb.push_back({4'd0, 1'b0});
        e = sb.pop_front();
        n_checks++;
        if ({q, ovf} !== {e.q, e.ovf}) begin
            n_fail++;
            $display("FAIL async_immediate: q=%0d ovf=%b, expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
        end
        sb.push_back({4'd0, 1'b0});
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({q, ovf} !== {e.q, e.ovf}) begin
            n_fail++;
            $display("FAIL async_held: q=%0d ovf=%b, expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
        end
        #2;
        clr_n = 1'b1;
        l = 1'b0; sat_wr = 1'b0; sat_in = 1'b0; ovf_clr = 1'b0;
        // sat_wr during reset must be ignored: counting past 9 still wraps
        for (int i = 1; i <= 10; i++) begin
            sb.push_back({4'(i % 10), (i == 10)});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({q, ovf} !== {e.q, e.ovf}) begin
                n_fail++;
                $display("FAIL async_resume[%0d]: q=%0d ovf=%b, expected q=%0d ovf=%b", i, q, ovf, e.q, e.ovf);
            end
        end
    endtask

    task automatic test_cascade();
        int         pulses;
        logic [7:0] e;
        pulses = 0;
        do_reset();
        cas_ce = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            if (hi_ceo) pulses++;
            csb.push_back({4'((i % 60) / 10), 4'((i % 60) % 10)});
            tick();
            e = csb.pop_front();
            n_checks++;
            if ({hi_q, lo_q} !== e) begin
                n_fail++;
                $display("FAIL cascade[%0d]: got %0d%0d, expected %0d%0d", i, hi_q, lo_q, e[7:4], e[3:0]);
            end
        end
        cas_ce = 1'b0;
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL cascade_hi_ceo: got %0d pulses, expected 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_clamp();
        test_runtime_modulus();
        test_free_run_hold();
        test_async_reset();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/vcb_mod_cled.md
VCB_MOD_CLED -- requirements
Module: vcb_mod_cled

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/modulus width in bits (legal 2..32).
REQ-002 SHALL have parameter SAT_DEF, default 0, reset value of the internal saturate-mode bit (0 = wrap, 1 = saturate).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ce  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction (1 = up, 0 = down).
REQ-007 SHALL have port l  input  1  synchronous load strobe.
REQ-008 SHALL have port di  input  WIDTH  load data.
REQ-009 SHALL have port m  input  WIDTH  runtime modulus maximum (count range 0..m inclusive).
REQ-010 SHALL have port sat_wr  input  1  strobe that writes sat_in into the saturate-mode bit.
REQ-011 SHALL have port sat_in  input  1  new saturate-mode value.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-013 SHALL have port q  output  WIDTH  registered count.
REQ-014 SHALL have port tc  output  1  terminal count, combinational from q, m and up.
REQ-015 SHALL have port ceo  output  1  cascade enable out.
REQ-016 SHALL have port ovf  output  1  registered sticky wrap/saturation event flag.

Function
REQ-017 SHALL apply next-state priority: clr_n low > l > ce > hold.
REQ-018 SHALL, on l=1, load q <= di when di <= m, else q <= m (clamp), regardless of ce and up; ovf SHALL be unaffected by load.
REQ-019 SHALL, on ce=1, up=1, l=0: q <= q+1 when q < m; q >= m is a terminal event: wrap mode q <= 0, saturate mode q <= m.
REQ-020 SHALL, on ce=1, up=0, l=0: q <= q-1 when 0 < q <= m; q == 0 is a terminal event: wrap mode q <= m, saturate mode q <= 0.
REQ-021 SHALL, on ce=1, up=0, l=0 with q > m (m lowered at runtime), set q <= m; this is not a terminal event.
REQ-022 SHALL treat ce=0 with l=0 as hold: q, ovf and the mode bit unchanged, except for the effects of sat_wr and ovf_clr.
REQ-023 SHALL drive tc = (up ? q >= m : q == 0) combinationally, with no dependency on ce or l.
REQ-024 SHALL drive ceo = ce & tc & ~l, so a load cycle never propagates a cascade enable.
REQ-025 SHALL set ovf to 1 on the clock edge ending any cycle with a terminal event (REQ-019/020), in both wrap and saturate modes.
REQ-026 SHALL clear ovf on ovf_clr=1; if a terminal event and ovf_clr coincide, ovf SHALL be 1 (set wins).
REQ-027 SHALL update the mode bit on sat_wr; the new mode SHALL govern only the cycle after the write, and the write cycle SHALL use the old mode.
REQ-028 SHALL, with m=0, keep q at 0; every ce cycle is a terminal event in either direction, so tc=1 and ceo=ce&~l.
REQ-029 SHALL perform all arithmetic modulo 2^WIDTH with no carry or borrow leaking outside q; at m = 2^WIDTH-1 the counter SHALL behave as a free-running binary counter.
REQ-030 SHALL produce a one-cycle ceo pulse per terminal event so that N instances chained ceo->ce form an N-digit mixed-radix counter.

Reset
REQ-031 SHALL, while clr_n=0, immediately force q=0, ovf=0 and mode bit=SAT_DEF, independent of clk.
REQ-032 SHALL ignore l, ce, sat_wr and ovf_clr while clr_n=0, and SHALL resume counting on the first rising clk edge after clr_n rises.
REQ-033 SHALL, when clr_n asserts in mid-count, abandon the count with no partial update; tc and ceo then follow REQ-023/024 from q=0.

Verification
REQ-034 SHALL cover the up wrap case: WIDTH=4, m=9, wrap, up, ce=1 for 12 cycles from reset -> q 1..9, 0, 1, 2; tc high only while q=9; ovf=1 from the edge after q=9.
REQ-035 SHALL cover the down saturate case: sat_wr with sat_in=1, l with di=2, up=0, ce=1 for 4 cycles -> q 1, 0, 0, 0; ovf set on the third edge; ovf_clr and a terminal event in the same cycle -> ovf stays 1.
REQ-036 SHALL cover load clamp and priority: m=5, l=1 with di=12, ce=1, up=1 -> q=5; ceo=0 during the load cycle even though tc=1.
REQ-037 SHALL cover runtime modulus reduction: q=8, then m changes to 3 -> up: next ce gives q=0 (wrap) with ovf set; down: next ce gives q=3 with ovf unchanged.
REQ-038 SHALL cover the cascade case: two instances, WIDTH=4, m=9 and m=5, low-digit ceo -> high-digit ce, 60 cycles -> the pair steps 00..59 and returns to 00; the high-digit ceo pulses once.
REQ-039 SHALL cover asynchronous reset: clr_n pulsed low between edges at q=7 -> q=0 and ovf=0 before the next edge; with ce held, q=1 on the first edge after release.
